// File: rtl/duty_slew_ctrl_pkg.sv
// rtl/duty_slew_ctrl_pkg.sv - shared state encoding and default parameters for the duty slew controller
package duty_slew_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_FAULT     = 2'd3
    } state_e;

    localparam int unsigned DEF_RESOLUTION = 12;
    localparam int unsigned DEF_STEP       = 64;
    localparam int unsigned DEF_TICK_DIV   = 1024;
    localparam int unsigned DEF_WDOG_TICKS = 256;

endpackage

// File: rtl/duty_slew_ctrl_if.sv
// rtl/duty_slew_ctrl_if.sv - target duty command handshake between host and slew controller
interface duty_slew_ctrl_if
    import duty_slew_ctrl_pkg::*;
#(
    parameter int unsigned RESOLUTION = DEF_RESOLUTION
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [RESOLUTION-1:0] cmd_duty_i;

    modport master (output cmd_valid_i, output cmd_duty_i, input  cmd_ready_o);
    modport slave  (input  cmd_valid_i, input  cmd_duty_i, output cmd_ready_o);
endinterface

// File: rtl/duty_slew_ctrl_tick_gen.sv
// rtl/duty_slew_ctrl_tick_gen.sv - free-running prescaler emitting a one-cycle tick every TICK_DIV clocks
module tick_gen #(
    parameter int unsigned TICK_DIV = 1024
) (
    input  logic clk_i,
    input  logic reset_n,
    output logic tick_o
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/duty_slew_ctrl.sv
// rtl/duty_slew_ctrl.sv - slew-rate-limited duty ramp with command watchdog feeding the PWM hub
module duty_slew_ctrl
    import duty_slew_ctrl_pkg::*;
#(
    parameter int unsigned RESOLUTION = DEF_RESOLUTION,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned WDOG_TICKS = DEF_WDOG_TICKS
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    duty_slew_ctrl_if.slave       cmd,
    output logic [RESOLUTION-1:0] duty_o,
    output logic                  at_target_o,
    output logic                  fault_o
);
    localparam int unsigned WDW = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;
    localparam logic [WDW-1:0]        WDOG_MAX = WDW'(WDOG_TICKS);
    localparam logic [RESOLUTION-1:0] STEP_R   = RESOLUTION'(STEP);
    localparam logic [RESOLUTION:0]   STEP_W   = {1'b0, STEP_R};

    logic                  tick;
    logic                  accept;
    logic [RESOLUTION-1:0] eff;
    logic [RESOLUTION:0]   diff, mag;

    logic [RESOLUTION-1:0] duty_q, duty_d;
    logic [RESOLUTION-1:0] target_q, target_d;
    logic [WDW-1:0]        wdog_q, wdog_d;
    logic                  fault_q, fault_d;
    logic                  at_target_q, at_target_d;
    logic                  ready_q;
    state_e                state_q, state_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    // Signed (RESOLUTION+1)-bit difference so the clamp to eff can never wrap past 0 or full scale.
    always_comb begin
        accept = cmd.cmd_valid_i & ready_q;
        eff    = accept ? cmd.cmd_duty_i : target_q;
        diff   = {1'b0, eff} - {1'b0, duty_q};
        mag    = diff[RESOLUTION] ? ({1'b0, duty_q} - {1'b0, eff}) : diff;

        duty_d   = duty_q;
        target_d = target_q;
        wdog_d   = wdog_q;
        fault_d  = fault_q;

        if (tick) begin
            if (mag <= STEP_W) begin
                duty_d = eff;
            end else if (diff[RESOLUTION]) begin
                duty_d = duty_q - STEP_R;
            end else begin
                duty_d = duty_q + STEP_R;
            end
        end

        if (accept) begin
            target_d = cmd.cmd_duty_i;
            wdog_d   = '0;
            fault_d  = 1'b0;
        end else if (tick && (WDOG_TICKS != 0) && (state_q != ST_FAULT)) begin
            wdog_d = wdog_q + WDW'(1);
            if (wdog_d == WDOG_MAX) begin
                fault_d  = 1'b1;
                target_d = '0;
            end
        end

        at_target_d = (duty_d == target_d);
    end

    always_comb begin
        state_d = state_q;
        if (fault_d) begin
            state_d = ST_FAULT;
        end else if (duty_d == target_d) begin
            state_d = ST_IDLE;
        end else if (target_d > duty_d) begin
            state_d = ST_RAMP_UP;
        end else begin
            state_d = ST_RAMP_DOWN;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            duty_q      <= '0;
            target_q    <= '0;
            wdog_q      <= '0;
            fault_q     <= 1'b0;
            at_target_q <= 1'b1;
            ready_q     <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            duty_q      <= duty_d;
            target_q    <= target_d;
            wdog_q      <= wdog_d;
            fault_q     <= fault_d;
            at_target_q <= at_target_d;
            ready_q     <= 1'b1;
            state_q     <= state_d;
        end
    end

    assign cmd.cmd_ready_o = ready_q;
    assign duty_o          = duty_q;
    assign at_target_o     = at_target_q;
    assign fault_o         = fault_q;
endmodule

// File: tb/tb_duty_slew_ctrl.sv
// tb/tb_duty_slew_ctrl.sv - directed vector bench for duty_slew_ctrl
module tb_duty_slew_ctrl;
    import duty_slew_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] duty;
    logic        at_target;
    logic        fault;
    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_n = 0;

    duty_slew_ctrl_if #(.RESOLUTION(12)) cmd_if ();

    duty_slew_ctrl #(
        .RESOLUTION (12),
        .STEP       (64),
        .TICK_DIV   (4),
        .WDOG_TICKS (8)
    ) dut (
        .clk_i       (clk),
        .reset_n     (reset_n),
        .cmd         (cmd_if.slave),
        .duty_o      (duty),
        .at_target_o (at_target),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [11:0] cmd;
        int          ncyc;
        logic [11:0] e_duty;
        logic        e_at;
        logic        e_fault;
        state_e      e_state;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic cyc(input logic v, input logic [11:0] d);
        cmd_if.cmd_valid_i = v;
        cmd_if.cmd_duty_i  = d;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        cmd_if.cmd_valid_i = 1'b0;
    endtask

    task automatic run_to_edge(input int target);
        while (edge_n < target) cyc(1'b0, 12'h000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cmd_if.cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        edge_n = 0;
        cyc(1'b0, 12'h000);
    endtask

    task automatic check_state(input string name, input state_e exp);
        check(name, 32'(dut.state_q), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        cmd_if.cmd_valid_i = 1'b0;
        cmd_if.cmd_duty_i  = 12'h000;

        vecs[0] = '{1'b1, 12'h100, 1, 12'h000, 1'b0, 1'b0, ST_RAMP_UP,   "acc_100"};
        vecs[1] = '{1'b0, 12'h000, 2, 12'h040, 1'b0, 1'b0, ST_RAMP_UP,   "up_tick1"};
        vecs[2] = '{1'b0, 12'h000, 4, 12'h080, 1'b0, 1'b0, ST_RAMP_UP,   "up_tick2"};
        vecs[3] = '{1'b0, 12'h000, 4, 12'h0C0, 1'b0, 1'b0, ST_RAMP_UP,   "up_tick3"};
        vecs[4] = '{1'b0, 12'h000, 4, 12'h100, 1'b1, 1'b0, ST_IDLE,      "up_tick4"};
        vecs[5] = '{1'b1, 12'h120, 1, 12'h100, 1'b0, 1'b0, ST_RAMP_UP,   "acc_120"};
        vecs[6] = '{1'b0, 12'h000, 3, 12'h120, 1'b1, 1'b0, ST_IDLE,      "no_overshoot"};
        vecs[7] = '{1'b1, 12'h080, 4, 12'h0E0, 1'b0, 1'b0, ST_RAMP_DOWN, "redir_dn1"};
        vecs[8] = '{1'b0, 12'h000, 4, 12'h0A0, 1'b0, 1'b0, ST_RAMP_DOWN, "redir_dn2"};
        vecs[9] = '{1'b0, 12'h000, 4, 12'h080, 1'b1, 1'b0, ST_IDLE,      "redir_land"};

        // Reset values while held, ready rises one edge after release
        repeat (3) @(negedge clk);
        check("rst_duty", 32'(duty), 32'h000);
        check("rst_at", 32'(at_target), 32'h1);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_ready", 32'(cmd_if.cmd_ready_o), 32'h0);
        reset_n = 1'b1;
        #1;
        check("ready_pre_edge", 32'(cmd_if.cmd_ready_o), 32'h0);
        @(negedge clk);
        cyc(1'b0, 12'h000);
        check("ready_post_edge", 32'(cmd_if.cmd_ready_o), 32'h1);
        check_state("rst_state", ST_IDLE);

        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].v, vecs[i].cmd);
            repeat (vecs[i].ncyc - 1) cyc(1'b0, 12'h000);
            check({vecs[i].name, "_duty"}, 32'(duty), 32'(vecs[i].e_duty));
            check({vecs[i].name, "_at"}, 32'(at_target), 32'(vecs[i].e_at));
            check({vecs[i].name, "_fault"}, 32'(fault), 32'(vecs[i].e_fault));
            check_state({vecs[i].name, "_state"}, vecs[i].e_state);
        end

        // Climb to 0xFC0 refreshing each tick, then finish at full scale without wrapping
        do_reset();
        for (int k = 1; k <= 63; k++) begin
            cyc(1'b1, 12'hFC0);
            repeat (3) cyc(1'b0, 12'h000);
        end
        check("climb_fc0", 32'(duty), 32'hFC0);
        cyc(1'b1, 12'hFFF);
        repeat (3) cyc(1'b0, 12'h000);
        check("full_scale", 32'(duty), 32'hFFF);
        check("full_scale_at", 32'(at_target), 32'h1);
        repeat (4) cyc(1'b0, 12'h000);
        check("no_wrap", 32'(duty), 32'hFFF);

        // Mid-ramp reversal
        do_reset();
        cyc(1'b1, 12'h400);
        check_state("rev_up_state", ST_RAMP_UP);
        run_to_edge(8);
        check("rev_at_080", 32'(duty), 32'h080);
        cyc(1'b1, 12'h000);
        check_state("rev_dn_state", ST_RAMP_DOWN);
        run_to_edge(12);
        check("rev_040", 32'(duty), 32'h040);
        run_to_edge(16);
        check("rev_000", 32'(duty), 32'h000);
        check_state("rev_idle_state", ST_IDLE);
        check("rev_at", 32'(at_target), 32'h1);

        // Watchdog expiry and recovery
        do_reset();
        cyc(1'b1, 12'h200);
        run_to_edge(29);
        cyc(1'b1, 12'h200);
        run_to_edge(32);
        check("wd_reach_200", 32'(duty), 32'h200);
        run_to_edge(59);
        check("wd_pre_fault", 32'(fault), 32'h0);
        run_to_edge(60);
        check("wd_fault", 32'(fault), 32'h1);
        check_state("wd_fault_state", ST_FAULT);
        check("wd_fault_duty", 32'(duty), 32'h200);
        check("wd_fault_at", 32'(at_target), 32'h0);
        run_to_edge(64);
        check("wd_fall1", 32'(duty), 32'h1C0);
        run_to_edge(92);
        check("wd_zero", 32'(duty), 32'h000);
        check("wd_zero_at", 32'(at_target), 32'h1);
        check_state("wd_zero_state", ST_FAULT);
        run_to_edge(100);
        check("wd_sticky", 32'(fault), 32'h1);
        cyc(1'b1, 12'h100);
        check("wd_clear", 32'(fault), 32'h0);
        check_state("wd_exit_state", ST_RAMP_UP);
        run_to_edge(104);
        check("wd_resume", 32'(duty), 32'h040);

        // Accept landing on the expiry tick
        do_reset();
        cyc(1'b1, 12'h040);
        run_to_edge(31);
        cyc(1'b1, 12'h080);
        check("exp_acc_fault", 32'(fault), 32'h0);
        check("exp_acc_duty", 32'(duty), 32'h080);
        check_state("exp_acc_state", ST_IDLE);
        run_to_edge(36);
        check("exp_acc_later", 32'(fault), 32'h0);

        // Asynchronous reset mid-ramp
        do_reset();
        cyc(1'b1, 12'h400);
        run_to_edge(12);
        check("mid_duty_0c0", 32'(duty), 32'h0C0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_duty", 32'(duty), 32'h000);
        check("async_at", 32'(at_target), 32'h1);
        check("async_ready", 32'(cmd_if.cmd_ready_o), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        edge_n = 0;
        cyc(1'b0, 12'h000);
        cyc(1'b1, 12'h080);
        run_to_edge(4);
        check("post_rst_040", 32'(duty), 32'h040);
        run_to_edge(8);
        check("post_rst_080", 32'(duty), 32'h080);
        check("post_rst_at", 32'(at_target), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
